// File: rtl/ram_sp_clr_pkg.sv
// Shared definitions for the clearable single-port RAM family: clear-engine
// state encodings, the default sweep value and a small state decode helper.
package ram_sp_clr_pkg;

    // Clear-engine states. INIT follows reset, CLEAR follows a clr request.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } clr_state_e;

    // Default value written to every word by the clear sweep.
    localparam logic [7:0] RAM_DEF_CLR_VAL = 8'h00;

    // True while the engine owns the write port. Any state other than IDLE
    // counts as sweeping, so a corrupted encoding keeps the array locked out.
    function automatic logic is_sweeping(input clr_state_e st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/ram_sp_clr_fsm.sv
// Clear engine for ram_sp_clr: state register, sweep pointer and the
// busy/ready/sweep-write controls derived from them.
module ram_sp_clr_fsm
    import ram_sp_clr_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              ready_o,
    output logic              sweep_we_o,
    output logic [ADDR_W-1:0] sweep_addr_o
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q;
    clr_state_e        state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              last_s;

    assign last_s = (ptr_q == LAST_PTR);

    // Next-state and pointer logic; a clr pulse always restarts from word 0.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT, ST_CLEAR: begin
                if (clr_i) begin
                    ptr_d = '0;
                end else if (last_s) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    // Output decode; the sweep skips its write in a restart cycle so the
    // first word written after clr is always word 0.
    always_comb begin
        busy_o       = is_sweeping(state_q);
        ready_o      = (state_q == ST_IDLE) && !clr_i;
        sweep_addr_o = ptr_q;
        if ((state_q == ST_INIT) || (state_q == ST_CLEAR)) begin
            sweep_we_o = !clr_i;
        end else begin
            sweep_we_o = 1'b0;
        end
    end

    // State and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with req/ready handshake, read-valid strobe,
// optional output register and a clear engine that sweeps the array to
// CLR_VAL after reset and on each clr request.
module ram_sp_clr
    import ram_sp_clr_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 3,
    parameter int                DEPTH   = 8,
    parameter int                OUT_REG = 0,
    parameter logic [DATA_W-1:0] CLR_VAL = DATA_W'(RAM_DEF_CLR_VAL)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic              rd_valid_o,
    output logic              busy_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              sweep_we_s;
    logic [ADDR_W-1:0] sweep_addr_s;
    logic              addr_ok_s;
    logic              acc_s;
    logic              wr_s;
    logic              rd_s;
    logic              rd1_q;
    logic [DATA_W-1:0] dat1_q;

    ram_sp_clr_fsm #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (clr_i),
        .busy_o       (busy_o),
        .ready_o      (ready_o),
        .sweep_we_o   (sweep_we_s),
        .sweep_addr_o (sweep_addr_s)
    );

    // Addresses at or beyond DEPTH are decoded as holes: writes dropped,
    // reads answered with CLR_VAL.
    assign addr_ok_s = (32'(addr_i) < 32'(DEPTH));
    assign acc_s     = req_i && ready_o;
    assign wr_s      = acc_s && we_i && addr_ok_s;
    assign rd_s      = acc_s && !we_i;

    // Array write port: the sweep and user writes are mutually exclusive
    // because ready is low whenever the sweep is active.
    always_ff @(posedge clk) begin
        if (sweep_we_s) begin
            mem_q[sweep_addr_s] <= CLR_VAL;
        end else if (wr_s) begin
            mem_q[addr_i] <= data_i;
        end
    end

    // First read stage; data holds its last value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q  <= 1'b0;
            dat1_q <= '0;
        end else begin
            rd1_q <= rd_s;
            if (rd_s) begin
                dat1_q <= addr_ok_s ? mem_q[addr_i] : CLR_VAL;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              rd2_q;
            logic [DATA_W-1:0] dat2_q;

            // Optional output register stage, loaded only by valid reads.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd2_q  <= 1'b0;
                    dat2_q <= '0;
                end else begin
                    rd2_q <= rd1_q;
                    if (rd1_q) begin
                        dat2_q <= dat1_q;
                    end
                end
            end

            assign data_o     = dat2_q;
            assign rd_valid_o = rd2_q;
        end else begin : g_no_out_reg
            assign data_o     = dat1_q;
            assign rd_valid_o = rd1_q;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sp_clr.sv
// Randomised and directed bench for ram_sp_clr. Three instances share one
// stimulus stream: DEPTH 8 / latency 1, DEPTH 8 / latency 2, and DEPTH 6 with
// a non-zero CLR_VAL. Each is compared against an abstract per-instance model
// (remaining-sweep counter, word array, read results scheduled by latency).
module tb_ram_sp_clr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_i;
    logic       req_i;
    logic       we_i;
    logic [2:0] addr_i;
    logic [7:0] data_i;
    logic [2:0] rdy;
    logic [2:0] rv;
    logic [2:0] bsy;
    logic [7:0] dout [3];

    int total = 0;
    int bad   = 0;

    int         m_depth [3] = '{8, 8, 6};
    int         m_lat   [3] = '{1, 2, 1};
    logic [7:0] m_clr   [3] = '{8'h00, 8'h00, 8'hC3};

    int         busy_left [3];
    logic [7:0] m_mem     [3][8];
    logic       slot_v    [3][4];
    logic [7:0] slot_d    [3][4];
    logic [7:0] m_last    [3];
    int         ecnt = 0;

    always #5 clk = ~clk;

    ram_sp_clr #(.DATA_W(8), .ADDR_W(3), .DEPTH(8), .OUT_REG(0), .CLR_VAL(8'h00)) u_a (
        .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .data_i(data_i), .ready_o(rdy[0]), .data_o(dout[0]),
        .rd_valid_o(rv[0]), .busy_o(bsy[0]));

    ram_sp_clr #(.DATA_W(8), .ADDR_W(3), .DEPTH(8), .OUT_REG(1), .CLR_VAL(8'h00)) u_b (
        .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .data_i(data_i), .ready_o(rdy[1]), .data_o(dout[1]),
        .rd_valid_o(rv[1]), .busy_o(bsy[1]));

    ram_sp_clr #(.DATA_W(8), .ADDR_W(3), .DEPTH(6), .OUT_REG(0), .CLR_VAL(8'hC3)) u_c (
        .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .data_i(data_i), .ready_o(rdy[2]), .data_o(dout[2]),
        .rd_valid_o(rv[2]), .busy_o(bsy[2]));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            busy_left[k] = m_depth[k];
            m_last[k]    = 8'h00;
            for (int s = 0; s < 4; s++) begin
                slot_v[k][s] = 1'b0;
                slot_d[k][s] = 8'h00;
            end
            for (int j = 0; j < 8; j++) begin
                m_mem[k][j] = 8'hxx;
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, check ready/busy, advance
    // the model across the rising edge, then check read outputs.
    task automatic cycle(input logic c, input logic r, input logic w,
                         input logic [2:0] a, input logic [7:0] d);
        logic exp_busy;
        logic exp_rdy;
        int   s;
        clr_i  = c;
        req_i  = r;
        we_i   = w;
        addr_i = a;
        data_i = d;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_busy = (busy_left[k] > 0);
            exp_rdy  = !exp_busy && !c;
            check_val($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(exp_busy));
            check_val($sformatf("ready[%0d]", k), 32'(rdy[k]), 32'(exp_rdy));
            if (c) begin
                busy_left[k] = m_depth[k];
            end else if (busy_left[k] > 0) begin
                busy_left[k] = busy_left[k] - 1;
                if (busy_left[k] == 0) begin
                    for (int j = 0; j < 8; j++) m_mem[k][j] = m_clr[k];
                end
            end else if (r) begin
                if (w) begin
                    if (int'(a) < m_depth[k]) m_mem[k][a] = d;
                end else begin
                    s = (ecnt + m_lat[k]) % 4;
                    slot_v[k][s] = 1'b1;
                    slot_d[k][s] = (int'(a) < m_depth[k]) ? m_mem[k][a] : m_clr[k];
                end
            end
        end
        ecnt++;
        @(negedge clk);
        s = ecnt % 4;
        for (int k = 0; k < 3; k++) begin
            if (slot_v[k][s]) m_last[k] = slot_d[k][s];
            check_val($sformatf("rd_valid[%0d]", k), 32'(rv[k]), 32'(slot_v[k][s]));
            check_val($sformatf("data_out[%0d]", k), 32'(dout[k]), 32'(m_last[k]));
            slot_v[k][s] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    // Asynchronous reset mid-cycle; outputs must drop without a clock edge.
    task automatic async_reset();
        clr_i = 1'b0;
        req_i = 1'b0;
        we_i  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("rst_rd_valid[%0d]", k), 32'(rv[k]), 32'd0);
            check_val($sformatf("rst_data_out[%0d]", k), 32'(dout[k]), 32'd0);
            check_val($sformatf("rst_busy[%0d]", k), 32'(bsy[k]), 32'd1);
            check_val($sformatf("rst_ready[%0d]", k), 32'(rdy[k]), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        clr_i  = 1'b0;
        req_i  = 1'b0;
        we_i   = 1'b0;
        addr_i = 3'd0;
        data_i = 8'h00;
        model_reset();
        #3;
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("por_busy[%0d]", k), 32'(bsy[k]), 32'd1);
            check_val($sformatf("por_ready[%0d]", k), 32'(rdy[k]), 32'd0);
            check_val($sformatf("por_rd_valid[%0d]", k), 32'(rv[k]), 32'd0);
            check_val($sformatf("por_data_out[%0d]", k), 32'(dout[k]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Initial sweep length on the 8-word instance.
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bsy[0]) break;
            n++;
            cycle(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        end
        check_val("init_busy_cycles", 32'(n), 32'd8);
        idle(2);

        // Every word reads back as the clear value.
        for (int a = 0; a < 8; a++) cycle(1'b0, 1'b1, 1'b0, 3'(a), 8'h00);
        idle(3);

        // Write then read the same word on the next cycle.
        cycle(1'b0, 1'b1, 1'b1, 3'd0, 8'hA5);
        cycle(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
        idle(3);

        // Back-to-back reads after two writes.
        cycle(1'b0, 1'b1, 1'b1, 3'd1, 8'h3C);
        cycle(1'b0, 1'b1, 1'b1, 3'd7, 8'hFF);
        cycle(1'b0, 1'b1, 1'b0, 3'd1, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 3'd7, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
        idle(3);

        // clr with req held: not accepted, sweep, then reads of word 1.
        cycle(1'b1, 1'b1, 1'b0, 3'd1, 8'h00);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 3'd1, 8'h00);
        idle(3);

        // Restart mid-sweep.
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        idle(4);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        idle(10);

        // Reset during sweep, then reset with reads in flight.
        cycle(1'b0, 1'b1, 1'b1, 3'd2, 8'h77);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        idle(3);
        async_reset();
        idle(10);
        cycle(1'b0, 1'b1, 1'b1, 3'd2, 8'h77);
        cycle(1'b0, 1'b1, 1'b0, 3'd2, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 3'd2, 8'h00);
        async_reset();
        idle(10);
        for (int a = 0; a < 3; a++) cycle(1'b0, 1'b1, 1'b0, 3'(a), 8'h00);
        idle(3);

        // Out-of-range word on the 6-word instance.
        cycle(1'b0, 1'b1, 1'b1, 3'd6, 8'h55);
        cycle(1'b0, 1'b1, 1'b0, 3'd6, 8'h00);
        for (int a = 0; a < 6; a++) cycle(1'b0, 1'b1, 1'b0, 3'(a), 8'h00);
        idle(3);

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 800; i++) begin
            if (($urandom % 300) == 0) begin
                async_reset();
            end else begin
                cycle((($urandom % 50) == 0) ? 1'b1 : 1'b0,
                      (($urandom % 4) != 0) ? 1'b1 : 1'b0,
                      1'($urandom % 2),
                      3'($urandom % 8),
                      8'($urandom));
            end
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
